// File: rtl/conv_window_sched_if.sv
// Request/result bundle between the window scheduler, the feature buffer and the output writer.
interface conv_window_sched_if #(
  parameter int unsigned DIM_W   = 8,
  parameter int unsigned OADDR_W = 16
);
  logic               start;
  logic [DIM_W-1:0]   cfg_width;
  logic [DIM_W-1:0]   cfg_height;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic               win_valid;
  logic               win_ready;
  logic [DIM_W-1:0]   win_row;
  logic [DIM_W-1:0]   win_col;
  logic               ofmap_we;
  logic [OADDR_W-1:0] ofmap_addr;

  // Scheduler side
  modport master (
    input  start, cfg_width, cfg_height, win_ready,
    output busy, done, cfg_err, win_valid, win_row, win_col, ofmap_we, ofmap_addr
  );

  // Job controller / feature buffer / writer side
  modport slave (
    output start, cfg_width, cfg_height, win_ready,
    input  busy, done, cfg_err, win_valid, win_row, win_col, ofmap_we, ofmap_addr
  );
endinterface

// File: rtl/conv_window_sched.sv
// Walks every valid 3x3 window of a WxH ifmap (stride 1, no padding) in raster
// order and tracks in-flight windows through the fixed-latency kernel pipeline.
// KERNEL_LAT must be at least 1.
module conv_window_sched #(
  parameter int unsigned DIM_W      = 8,
  parameter int unsigned KERNEL_LAT = 4,
  parameter int unsigned OADDR_W    = 16
) (
  input logic                 clk,
  input logic                 rst,
  conv_window_sched_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DIM_W-1:0]      ow_m1_q, oh_m1_q;
  logic [DIM_W-1:0]      row_q, col_q;
  logic [KERNEL_LAT-1:0] inflight_q, inflight_d;
  logic [OADDR_W-1:0]    addr_q;
  logic                  cfg_err_q, busy_q, done_q, win_valid_q;

  logic                  start_c, cfg_bad_c, accept_c, last_win_c;

  // Handshake decode
  always_comb begin
    start_c    = (state_q == S_IDLE) && bus.start;
    cfg_bad_c  = (bus.cfg_width < DIM_W'(3)) || (bus.cfg_height < DIM_W'(3));
    accept_c   = win_valid_q && bus.win_ready;
    last_win_c = (row_q == oh_m1_q) && (col_q == ow_m1_q);
    inflight_d = (inflight_q << 1) | KERNEL_LAT'(accept_c);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_c) state_d = cfg_bad_c ? S_DONE : S_RUN;
      S_RUN:   if (accept_c && last_win_c) state_d = S_DRAIN;
      // Leave once the pipeline will be empty after this edge, i.e. after the last write
      S_DRAIN: if (inflight_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and state-decoded status flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q      <= (state_d == S_DONE);
      win_valid_q <= (state_d == S_RUN);
    end
  end

  // Latched config and raster window counters
  always_ff @(posedge clk) begin
    if (rst) begin
      ow_m1_q   <= '0;
      oh_m1_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      cfg_err_q <= 1'b0;
    end else if (start_c) begin
      ow_m1_q   <= bus.cfg_width - DIM_W'(3);
      oh_m1_q   <= bus.cfg_height - DIM_W'(3);
      row_q     <= '0;
      col_q     <= '0;
      cfg_err_q <= cfg_bad_c;
    end else if (accept_c) begin
      if (col_q == ow_m1_q) begin
        col_q <= '0;
        row_q <= row_q + DIM_W'(1);
      end else begin
        col_q <= col_q + DIM_W'(1);
      end
    end
  end

  // In-flight shift register and output address; results retire in raster order
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      addr_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (start_c) begin
        addr_q <= '0;
      end else if (inflight_q[KERNEL_LAT-1]) begin
        addr_q <= addr_q + OADDR_W'(1);
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = row_q;
  assign bus.win_col    = col_q;
  assign bus.ofmap_we   = inflight_q[KERNEL_LAT-1];
  assign bus.ofmap_addr = addr_q;

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: per-cycle vector table plus hand-written
// reset, mid-run and back-to-back sequences.
module tb_conv_window_sched;
  localparam int unsigned DIM_W   = 8;
  localparam int unsigned OADDR_W = 16;
  localparam int unsigned KLAT    = 4;

  logic clk = 1'b0;
  logic rst;

  conv_window_sched_if #(.DIM_W(DIM_W), .OADDR_W(OADDR_W)) bus ();

  conv_window_sched #(
    .DIM_W(DIM_W), .KERNEL_LAT(KLAT), .OADDR_W(OADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // One record per cycle: inputs driven this cycle, outputs expected this cycle
  typedef struct {
    logic        start;
    logic [7:0]  w, h;
    logic        rdy;
    logic        v, b, d, e, we;
    logic [7:0]  row, col;
    logic [15:0] addr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input int start, input int w, input int h, input int rdy,
                              input int v, input int b, input int d, input int e,
                              input int we, input int row, input int col, input int addr);
    vec_t r;
    r.start = 1'(start); r.w = 8'(w); r.h = 8'(h); r.rdy = 1'(rdy);
    r.v = 1'(v); r.b = 1'(b); r.d = 1'(d); r.e = 1'(e); r.we = 1'(we);
    r.row = 8'(row); r.col = 8'(col); r.addr = 16'(addr);
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk({tag, ".done"}, 32'(bus.done), 0);
    chk({tag, ".cfg_err"}, 32'(bus.cfg_err), 0);
    chk({tag, ".win_valid"}, 32'(bus.win_valid), 0);
    chk({tag, ".win_row"}, 32'(bus.win_row), 0);
    chk({tag, ".win_col"}, 32'(bus.win_col), 0);
    chk({tag, ".ofmap_we"}, 32'(bus.ofmap_we), 0);
    chk({tag, ".ofmap_addr"}, 32'(bus.ofmap_addr), 0);
  endtask

  initial begin
    int nwr;
    int done_cyc;
    int cyc;

    // Job A: W=H=4, ready high. Windows at 1-4, writes 5-8, done 9.
    add(1,4,4,1, 0,0,0,0,0, 0,0,0);
    add(0,4,4,1, 1,1,0,0,0, 0,0,0);
    add(0,4,4,1, 1,1,0,0,0, 0,1,0);
    add(0,4,4,1, 1,1,0,0,0, 1,0,0);
    add(0,4,4,1, 1,1,0,0,0, 1,1,0);
    add(0,4,4,1, 0,1,0,0,1, 0,0,0);
    add(0,4,4,1, 0,1,0,0,1, 0,0,1);
    add(0,4,4,1, 0,1,0,0,1, 0,0,2);
    add(0,4,4,1, 0,1,0,0,1, 0,0,3);
    add(0,4,4,1, 0,0,1,0,0, 0,0,4);
    add(0,4,4,1, 0,0,0,0,0, 0,0,4);
    // Job B: W=5, H=3, ready toggling. Accepts at 1,3,5; writes at 5,7,9; done 10.
    add(1,5,3,1, 0,0,0,0,0, 0,0,4);
    add(0,5,3,1, 1,1,0,0,0, 0,0,0);
    add(0,5,3,0, 1,1,0,0,0, 0,1,0);
    add(0,5,3,1, 1,1,0,0,0, 0,1,0);
    add(0,5,3,0, 1,1,0,0,0, 0,2,0);
    add(0,5,3,1, 1,1,0,0,1, 0,2,0);
    add(0,5,3,0, 0,1,0,0,0, 0,0,1);
    add(0,5,3,1, 0,1,0,0,1, 0,0,1);
    add(0,5,3,0, 0,1,0,0,0, 0,0,2);
    add(0,5,3,1, 0,1,0,0,1, 0,0,2);
    add(0,5,3,0, 0,0,1,0,0, 0,0,3);
    add(0,5,3,1, 0,0,0,0,0, 0,0,3);
    // Job C: W=2, H=10 is illegal: done+cfg_err at 1, cfg_err stays set.
    add(1,2,10,1, 0,0,0,0,0, 0,0,3);
    add(0,2,10,1, 0,0,1,1,0, 0,0,0);
    add(0,2,10,1, 0,0,0,1,0, 0,0,0);
    // Job D: W=H=3, single window; start clears cfg_err; done at 1+1+KLAT.
    add(1,3,3,1, 0,0,0,1,0, 0,0,0);
    add(0,3,3,1, 1,1,0,0,0, 0,0,0);
    add(0,3,3,1, 0,1,0,0,0, 0,0,0);
    add(0,3,3,1, 0,1,0,0,0, 0,0,0);
    add(0,3,3,1, 0,1,0,0,0, 0,0,0);
    add(0,3,3,1, 0,1,0,0,1, 0,0,0);
    add(0,3,3,1, 0,0,1,0,0, 0,0,1);
    add(0,3,3,1, 0,0,0,0,0, 0,0,1);

    // Reset state
    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_width = '0; bus.cfg_height = '0; bus.win_ready = 1'b0;
    step();
    step();
    chk_reset_values("reset");
    rst = 1'b0;
    step();

    // Table-driven jobs
    for (int i = 0; i < vecs.size(); i++) begin
      bus.start      = vecs[i].start;
      bus.cfg_width  = vecs[i].w;
      bus.cfg_height = vecs[i].h;
      bus.win_ready  = vecs[i].rdy;
      chk($sformatf("vec%0d.win_valid", i), 32'(bus.win_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].b));
      chk($sformatf("vec%0d.done", i), 32'(bus.done), 32'(vecs[i].d));
      chk($sformatf("vec%0d.cfg_err", i), 32'(bus.cfg_err), 32'(vecs[i].e));
      chk($sformatf("vec%0d.ofmap_we", i), 32'(bus.ofmap_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d.ofmap_addr", i), 32'(bus.ofmap_addr), 32'(vecs[i].addr));
      if (vecs[i].v) begin
        chk($sformatf("vec%0d.win_row", i), 32'(bus.win_row), 32'(vecs[i].row));
        chk($sformatf("vec%0d.win_col", i), 32'(bus.win_col), 32'(vecs[i].col));
      end
      step();
    end

    // W=H=6 job, rst pulsed on the 5th accept (cycle 5)
    bus.start = 1'b1; bus.cfg_width = 8'd6; bus.cfg_height = 8'd6; bus.win_ready = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_values("midrst");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("midrst.no_we%0d", k), 32'(bus.ofmap_we), 0);
      chk($sformatf("midrst.idle%0d", k), 32'(bus.busy), 0);
      step();
    end

    // Fresh W=H=6 job: second start and cfg_width change mid-RUN are ignored
    bus.start = 1'b1; bus.cfg_width = 8'd6; bus.cfg_height = 8'd6;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("job6.row%0d", k), 32'(bus.win_row), (k == 4) ? 1 : 0);
      chk($sformatf("job6.col%0d", k), 32'(bus.win_col), (k == 4) ? 0 : k);
      if (k == 1) begin
        bus.start = 1'b1;
        bus.cfg_width = 8'd10;
      end
      if (k == 2) bus.start = 1'b0;
      if (k == 4) begin
        chk("job6.first_we", 32'(bus.ofmap_we), 1);
        chk("job6.first_addr", 32'(bus.ofmap_addr), 0);
      end
      step();
    end
    nwr = 1;
    done_cyc = -1;
    cyc = 6;
    for (int k = 0; k < 40; k++) begin
      if (bus.ofmap_we) begin
        chk($sformatf("job6.addr%0d", nwr), 32'(bus.ofmap_addr), 32'(nwr));
        nwr++;
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      step();
      cyc++;
    end
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL job6.timeout: got no done expected done at cycle 21");
    end
    checks++;
    chk("job6.done_cycle", 32'(done_cyc), 21);
    chk("job6.writes", 32'(nwr), 16);
    step();

    // Back-to-back: start held high is re-accepted in the IDLE cycle after done
    bus.cfg_width = 8'd3; bus.cfg_height = 8'd3; bus.start = 1'b1;
    step();
    cyc = 1;
    done_cyc = -1;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      step();
      cyc++;
    end
    chk("b2b.done_cycle", 32'(done_cyc), 32'(2 + KLAT));
    step();
    chk("b2b.idle_busy", 32'(bus.busy), 0);
    step();
    bus.start = 1'b0;
    chk("b2b.restart_valid", 32'(bus.win_valid), 1);
    chk("b2b.restart_busy", 32'(bus.busy), 1);
    chk("b2b.restart_row", 32'(bus.win_row), 0);
    chk("b2b.restart_col", 32'(bus.win_col), 0);
    done_cyc = -1;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) begin
        done_cyc = k;
        break;
      end
      step();
    end
    chk("b2b.second_done_delay", 32'(done_cyc), 32'(1 + KLAT));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_window_sched.md
# conv_window_sched

Sequencing controller for the 2-channel 3x3 fp16 convolution kernel datapath. On `start` it latches the feature-map size and walks every valid 3x3 window position (stride 1, no padding) in raster order. It issues one window request per accepted cycle to the feature buffer, which drives the kernel's ifmap inputs. It tracks in-flight windows through the fixed-latency kernel pipeline and emits a write strobe and linear output address for every result.

## Interface
Parameters:
- `DIM_W`, default 8: width of size and coordinate fields.
- `KERNEL_LAT`, default 4: cycles from an accepted window to a valid kernel `ofmap`. Must be at least 1.
- `OADDR_W`, default 16: output address width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a job. Sampled only in IDLE.
- `cfg_width`  in  DIM_W: ifmap width W. Latched on an accepted `start`.
- `cfg_height`  in  DIM_W: ifmap height H. Latched on an accepted `start`.
- `busy`  out  1: high in RUN and DRAIN.
- `done`  out  1: one-cycle pulse at job end.
- `cfg_err`  out  1: high with `done` when W<3 or H<3; cleared on the next accepted `start`.
- `win_valid`  out  1: window request valid.
- `win_ready`  in  1: feature buffer accepts the request.
- `win_row`  out  DIM_W: top-left row of the window.
- `win_col`  out  DIM_W: top-left column of the window.
- `ofmap_we`  out  1: kernel `ofmap` is valid this cycle and is to be written.
- `ofmap_addr`  out  OADDR_W: linear output index.

## Operation
- Output dimensions: OW=W-2, OH=H-2. The block issues OW*OH windows.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 latches the config and clears row, col, address and `cfg_err`.
  - If W<3 or H<3, go to DONE with `cfg_err` set. Otherwise go to RUN.
- RUN:
  - `win_valid`=1. The request is accepted when `win_valid & win_ready`.
  - On accept: col++. If col=OW-1, col wraps to 0 and row++.
  - Accepting window (OH-1, OW-1) moves to DRAIN.
  - `win_row` and `win_col` hold stable while `win_ready`=0.
- In-flight tracking: a KERNEL_LAT-deep valid shift register. Its input is the accept strobe. It advances every cycle, unconditionally; the datapath has no stall.
  - `ofmap_we` is the last stage of the register.
  - `ofmap_addr` starts at 0 and increments after each `ofmap_we`. Results come out in raster order, so address = row*OW + col.
- DRAIN: `win_valid`=0. Move to DONE in the cycle after the shift register becomes all-zero, i.e. after the last `ofmap_we`.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Arithmetic:
  - OW*OH is computed at OADDR_W bits.
  - Configurations where OW*OH > 2^OADDR_W are unsupported, and the bench does not drive them.
  - Counters compare against OW-1 and OH-1 as held in the latched registers.
- `start` in RUN, DRAIN or DONE is ignored. `cfg_*` changes after latch have no effect.
- Reset:
  - `rst` in any state returns to IDLE.
  - Values after reset: `busy`=0, `done`=0, `cfg_err`=0, `win_valid`=0, `win_row`=0, `win_col`=0, `ofmap_we`=0, `ofmap_addr`=0.
  - The shift register is cleared, so in-flight results are discarded: no `ofmap_we` after reset.

## Timing
- `start` accepted at cycle t: `busy`=1 and `win_valid`=1 from t+1.
- A window accepted at cycle a produces `ofmap_we` at a+KERNEL_LAT.
- With `win_ready` tied high, windows are accepted at t+1 … t+N, where N=OW*OH.
  - Last `ofmap_we` at t+N+KERNEL_LAT.
  - `done` at t+N+KERNEL_LAT+1; IDLE at t+N+KERNEL_LAT+2.
- Error path: `done`=1 and `cfg_err`=1 at t+1, with `busy`=0 throughout.
- Back-to-back jobs: `start` held high is accepted again in the first IDLE cycle after `done`.
- `win_ready` low stalls only the issue side. Results already in flight still retire on schedule.

## Test plan
- W=4, H=4, KERNEL_LAT=4, `win_ready`=1, start at cycle 0:
  - windows (0,0), (0,1), (1,0), (1,1) at cycles 1–4;
  - `ofmap_we` at 5–8 with addr 0–3;
  - `done` at 9.
- W=5, H=3, `win_ready` toggling 1,0,1,0…: windows (0,0), (0,1), (0,2) each held until accepted. Three writes with addr 0,1,2, each exactly KERNEL_LAT after its accept.
- W=2, H=10: `done` and `cfg_err` pulse at cycle 1; no `win_valid` and no `ofmap_we`. A following valid job clears `cfg_err`.
- W=H=3: exactly one window (0,0) and one write, addr 0; `done` at 1+1+KERNEL_LAT.
- Job W=H=6:
  - `rst` asserted for 1 cycle at the 5th accept: everything returns to reset values next cycle and no further `ofmap_we` appears.
  - A new job then starts from (0,0), addr 0.
- Second `start` pulse mid-RUN is ignored. `cfg_width` changed mid-RUN does not alter the window sequence.
